fletcher_frame_appender: RTL and testbench

Stream-framing stage wrapped around the Fletcher-32 checksum core. It forwards a 16-bit payload stream unchanged, feeds every accepted word into an internal checksum instance, and closes each frame by appending the two 16-bit checksum words. It sits between the write-side data source and the FIFO/link that consumes checksummed frames.

---
 rtl/fletcher_frame_appender_pkg.sv | 15 +
 rtl/FletcherChecksum.sv | 54 +++++
 rtl/fletcher_frame_appender.sv | 111 +++++++++++
 tb/tb_fletcher_frame_appender.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fletcher_frame_appender_pkg.sv
// Shared widths and FSM encoding for the Fletcher-32 frame appender.
package fletcher_frame_appender_pkg;

    localparam int FletcherWidth = 32;
    localparam int HalfWidth     = FletcherWidth / 2;

    typedef enum logic [2:0] {
        CLEAR   = 3'd0,
        PASS    = 3'd1,
        DRAIN   = 3'd2,
        EMIT_HI = 3'd3,
        EMIT_LO = 3'd4
    } state_t;

endpackage

// File: rtl/FletcherChecksum.sv
// Fletcher checksum core: one input register stage plus one accumulate stage,
// so dout reflects a word two cycles after it is presented with en high.
module FletcherChecksum #(
    parameter int Width = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [Width/2-1:0] din,
    output logic [Width-1:0]   dout
);
    localparam int H = Width / 2;

    logic [H-1:0] din_q;
    logic         en_q;
    logic [H-1:0] sum1;
    logic [H-1:0] sum2;
    logic [H-1:0] sum1_nxt;
    logic [H-1:0] sum2_nxt;

    // Operands stay below 2^H-1 except din, so one conditional subtract
    // is enough for the ones'-complement style modulo.
    function automatic logic [H-1:0] add_mod(input logic [H-1:0] a, input logic [H-1:0] b);
        logic [H:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, {H{1'b1}}})
            s = s - {1'b0, {H{1'b1}}};
        return s[H-1:0];
    endfunction

    always_comb begin
        sum1_nxt = add_mod(sum1, din_q);
        sum2_nxt = add_mod(sum2, sum1_nxt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            din_q <= '0;
            en_q  <= 1'b0;
            sum1  <= '0;
            sum2  <= '0;
        end else begin
            din_q <= din;
            en_q  <= en;
            if (en_q) begin
                sum1 <= sum1_nxt;
                sum2 <= sum2_nxt;
            end
        end
    end

    assign dout = {sum2, sum1};

endmodule

// File: rtl/fletcher_frame_appender.sv
// Forwards a 16-bit payload stream unchanged and closes each frame with its
// Fletcher-32 checksum (high word, then low word carrying m_last).
module fletcher_frame_appender
    import fletcher_frame_appender_pkg::*;
#(
    parameter int CksumLatency = 2,
    parameter int MaxWords     = 16384
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [HalfWidth-1:0] s_data,
    input  logic                 s_last,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [HalfWidth-1:0] m_data,
    output logic                 m_last,
    output logic                 trunc
);
    localparam int CntW = $clog2(MaxWords + 1);
    localparam int LatW = $clog2(CksumLatency + 1);

    state_t                   state;
    state_t                   state_n;
    logic [CntW-1:0]          word_cnt;
    logic [LatW-1:0]          lat_cnt;
    logic                     hs;
    logic                     at_max;
    logic                     frame_end;
    logic                     core_en;
    logic                     core_rst;
    logic [FletcherWidth-1:0] dout;

    assign at_max    = (word_cnt == CntW'(MaxWords - 1));
    assign hs        = (state == PASS) && s_valid && m_ready;
    assign frame_end = hs && (s_last || at_max);
    assign core_rst  = rst || (state == CLEAR);

    always_comb begin
        state_n = state;
        s_ready = 1'b0;
        m_valid = 1'b0;
        m_data  = '0;
        m_last  = 1'b0;
        core_en = 1'b0;
        if (!rst) begin
            case (state)
                CLEAR:   state_n = PASS;
                PASS: begin
                    m_valid = s_valid;
                    s_ready = m_ready;
                    m_data  = s_data;
                    core_en = hs;
                    if (frame_end)
                        state_n = DRAIN;
                end
                DRAIN:   if (lat_cnt == '0) state_n = EMIT_HI;
                EMIT_HI: begin
                    m_valid = 1'b1;
                    m_data  = dout[FletcherWidth-1:HalfWidth];
                    if (m_ready)
                        state_n = EMIT_LO;
                end
                EMIT_LO: begin
                    m_valid = 1'b1;
                    m_data  = dout[HalfWidth-1:0];
                    m_last  = 1'b1;
                    if (m_ready)
                        state_n = CLEAR;
                end
                default: state_n = CLEAR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLEAR;
            word_cnt <= '0;
            lat_cnt  <= '0;
            trunc    <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                CLEAR: word_cnt <= '0;
                PASS: if (hs) begin
                    word_cnt <= word_cnt + CntW'(1);
                    if (frame_end)
                        lat_cnt <= LatW'(CksumLatency - 1);
                    // s_last on the limit word is a normal close, not a truncation
                    if (at_max && !s_last)
                        trunc <= 1'b1;
                end
                DRAIN: if (lat_cnt != '0) lat_cnt <= lat_cnt - LatW'(1);
                default: ;
            endcase
        end
    end

    FletcherChecksum #(
        .Width (FletcherWidth)
    ) u_cksum (
        .clk  (clk),
        .rst  (core_rst),
        .en   (core_en),
        .din  (s_data),
        .dout (dout)
    );

endmodule

// File: tb/tb_fletcher_frame_appender.sv
// Self-checking bench: table-driven frames plus hand sequences for stalls,
// truncation and reset. DUT A uses defaults, DUT B uses MaxWords=4.
module tb_fletcher_frame_appender;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        s_valid, s_last, m_ready;
    logic [15:0] s_data;

    logic        s_ready_a, m_valid_a, m_last_a, trunc_a, s_valid_a;
    logic        s_ready_b, m_valid_b, m_last_b, trunc_b, s_valid_b;
    logic [15:0] m_data_a, m_data_b;
    logic        s_ready, m_valid, m_last, trunc;
    logic [15:0] m_data;

    always #5 clk = ~clk;

    assign s_valid_a = s_valid & ~sel;
    assign s_valid_b = s_valid & sel;
    assign s_ready   = sel ? s_ready_b : s_ready_a;
    assign m_valid   = sel ? m_valid_b : m_valid_a;
    assign m_data    = sel ? m_data_b  : m_data_a;
    assign m_last    = sel ? m_last_b  : m_last_a;
    assign trunc     = sel ? trunc_b   : trunc_a;

    fletcher_frame_appender dut_a (
        .clk(clk), .rst(rst), .s_valid(s_valid_a), .s_ready(s_ready_a),
        .s_data(s_data), .s_last(s_last), .m_valid(m_valid_a), .m_ready(m_ready),
        .m_data(m_data_a), .m_last(m_last_a), .trunc(trunc_a)
    );

    fletcher_frame_appender #(.CksumLatency(2), .MaxWords(4)) dut_b (
        .clk(clk), .rst(rst), .s_valid(s_valid_b), .s_ready(s_ready_b),
        .s_data(s_data), .s_last(s_last), .m_valid(m_valid_b), .m_ready(m_ready),
        .m_data(m_data_b), .m_last(m_last_b), .trunc(trunc_b)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          hs_cyc  = 0;
    int          stab_err = 0;
    bit          rand_rdy;
    bit          tx_last_en;
    logic [15:0] tx_q[$];
    logic [15:0] mon_data[$];
    logic        mon_last[$];
    int          mon_cyc[$];
    logic        pv_stall = 1'b0;
    logic [15:0] pv_data;
    logic        pv_last;

    always @(posedge clk) cyc <= cyc + 1;

    // Records every accepted output word and flags any change while stalled.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_valid && m_ready) begin
                mon_data.push_back(m_data);
                mon_last.push_back(m_last);
                mon_cyc.push_back(cyc);
            end
            if (pv_stall && (!m_valid || m_data !== pv_data || m_last !== pv_last))
                stab_err++;
            pv_stall = m_valid && !m_ready;
            pv_data  = m_data;
            pv_last  = m_last;
        end else begin
            pv_stall = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] fl32(input logic [15:0] q[$]);
        int unsigned a = 0;
        int unsigned b = 0;
        foreach (q[i]) begin
            a = (a + q[i]) % 65535;
            b = (b + a) % 65535;
        end
        return {b[15:0], a[15:0]};
    endfunction

    function automatic logic [15:0] out_at(input int idx);
        if (idx < mon_data.size()) return mon_data[idx];
        return 16'hxxxx;
    endfunction

    function automatic logic last_at(input int idx);
        if (idx < mon_last.size()) return mon_last[idx];
        return 1'bx;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) m_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_frame(input int gap_pct);
        int i = 0;
        int g = 0;
        bit hs;
        while (i < tx_q.size() && g < 20000) begin
            if (!s_valid && $urandom_range(0, 99) >= gap_pct) begin
                s_valid = 1'b1;
                s_data  = tx_q[i];
                s_last  = tx_last_en && (i == tx_q.size() - 1);
            end
            @(negedge clk);
            hs = s_valid && s_ready;
            if (hs) hs_cyc = cyc;
            tick();
            if (hs) begin
                s_valid = 1'b0;
                s_last  = 1'b0;
                i++;
            end
            g++;
        end
        if (g >= 20000) chk("send timeout", i, tx_q.size());
    endtask

    task automatic wait_out(input int target);
        int g = 0;
        while (mon_data.size() < target && g < 5000) begin
            tick();
            g++;
        end
        if (g >= 5000) chk("output timeout", mon_data.size(), target);
    endtask

    task automatic check_frame(input string tag, input int base, input logic [15:0] w[$],
                               input logic [31:0] cks);
        int errs = 0;
        int n = w.size();
        for (int i = 0; i < n; i++)
            if (out_at(base + i) !== w[i] || last_at(base + i) !== 1'b0) errs++;
        chk({tag, " payload errors"}, errs, 0);
        chk({tag, " cksum hi"}, out_at(base + n), cks[31:16]);
        chk({tag, " cksum lo"}, out_at(base + n + 1), cks[15:0]);
        chk({tag, " last flags"}, {last_at(base + n), last_at(base + n + 1)}, 2'b01);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        int          n;
        logic [15:0] w [3];
        logic [15:0] hi;
        logic [15:0] lo;
    } vec_t;

    vec_t        tbl [5];
    logic [15:0] exp_q[$];
    logic [15:0] f1[$];
    int          base;
    int          last_hs;
    int          len1, len2;

    initial begin
        tbl[0] = '{3, '{16'h6261, 16'h6463, 16'h6665}, 16'h5650, 16'h2D2A};
        tbl[1] = '{1, '{16'h0061, 16'h0000, 16'h0000}, 16'h0061, 16'h0061};
        tbl[2] = '{2, '{16'hFFFF, 16'h0001, 16'h0000}, 16'h0001, 16'h0001};
        tbl[3] = '{3, '{16'h0001, 16'h0002, 16'h0003}, 16'h000A, 16'h0006};
        tbl[4] = '{2, '{16'hFFFF, 16'hFFFF, 16'h0000}, 16'h0000, 16'h0000};

        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
        sel = 1'b0; rand_rdy = 1'b0; tx_last_en = 1'b1;
        repeat (2) tick();
        rst = 1'b0;

        // Reset state: first cycle after reset is CLEAR even with m_ready high
        @(negedge clk);
        chk("reset s_ready", s_ready, 0);
        chk("reset m_valid", m_valid, 0);
        chk("reset m_data", m_data, 0);
        chk("reset m_last", m_last, 0);
        chk("reset trunc", trunc, 0);
        tick();
        @(negedge clk);
        chk("pass s_ready", s_ready, 1);
        tick();

        for (int v = 0; v < 5; v++) begin
            base = mon_data.size();
            tx_q.delete();
            exp_q.delete();
            for (int j = 0; j < tbl[v].n; j++) begin
                tx_q.push_back(tbl[v].w[j]);
                exp_q.push_back(tbl[v].w[j]);
            end
            send_frame(0);
            last_hs = hs_cyc;
            wait_out(base + tbl[v].n + 2);
            check_frame($sformatf("vec%0d", v), base, exp_q, {tbl[v].hi, tbl[v].lo});
            if (v == 0) begin
                chk("cksum latency",
                    (mon_cyc.size() > base + 3) ? mon_cyc[base + 3] - last_hs : -1, 3);
                chk("lo follows hi",
                    (mon_cyc.size() > base + 4) ? mon_cyc[base + 4] - mon_cyc[base + 3] : -1, 1);
            end
            chk($sformatf("vec%0d trunc", v), trunc, 0);
        end

        // Back-to-back random frames with random s_valid gaps
        base = mon_data.size();
        len1 = $urandom_range(1, 2048);
        len2 = $urandom_range(1, 2048);
        tx_q.delete();
        for (int i = 0; i < len1; i++) tx_q.push_back(16'($urandom));
        send_frame(30);
        f1 = tx_q;
        tx_q.delete();
        for (int i = 0; i < len2; i++) tx_q.push_back(16'($urandom));
        send_frame(30);
        wait_out(base + len1 + len2 + 4);
        check_frame("b2b frame1", base, f1, fl32(f1));
        check_frame("b2b frame2", base + len1 + 2, tx_q, fl32(tx_q));

        // Random downstream backpressure
        base = mon_data.size();
        tx_q.delete();
        for (int i = 0; i < 24; i++) tx_q.push_back(16'($urandom));
        rand_rdy = 1'b1;
        send_frame(20);
        wait_out(base + 26);
        rand_rdy = 1'b0;
        m_ready  = 1'b1;
        repeat (4) tick();
        chk("bp word count", mon_data.size() - base, 26);
        check_frame("bp", base, tx_q, fl32(tx_q));

        // Forced stall across both checksum words
        base = mon_data.size();
        tx_q = '{16'h6261, 16'h6463, 16'h6665};
        send_frame(0);
        m_ready = 1'b0;
        repeat (8) tick();
        @(negedge clk);
        chk("stall hi valid", m_valid, 1);
        chk("stall hi data", m_data, 16'h5650);
        chk("stall hi last", m_last, 0);
        tick();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        repeat (5) tick();
        @(negedge clk);
        chk("stall lo valid", m_valid, 1);
        chk("stall lo data", m_data, 16'h2D2A);
        chk("stall lo last", m_last, 1);
        tick();
        m_ready = 1'b1;
        wait_out(base + 5);
        repeat (4) tick();
        chk("stall word count", mon_data.size() - base, 5);
        check_frame("stall", base, tx_q, 32'h56502D2A);
        chk("stability while stalled", stab_err, 0);

        // Truncation at MaxWords=4: words 5-6 open the next frame
        sel = 1'b1;
        tick();
        base = mon_data.size();
        tx_last_en = 1'b0;
        tx_q = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6};
        send_frame(0);
        tx_last_en = 1'b1;
        tx_q = '{16'd7};
        send_frame(0);
        wait_out(base + 11);
        exp_q = '{16'd1, 16'd2, 16'd3, 16'd4};
        check_frame("trunc frame1", base, exp_q, 32'h0014_000A);
        exp_q = '{16'd5, 16'd6, 16'd7};
        check_frame("trunc frame2", base + 6, exp_q, 32'h0022_0012);
        chk("trunc sticky", trunc, 1);

        // s_last on the limit word: single close, no truncation
        pulse_reset();
        tick();
        base = mon_data.size();
        tx_q = '{16'd8, 16'd9, 16'd10, 16'd11};
        send_frame(0);
        wait_out(base + 6);
        repeat (10) tick();
        chk("limit+last count", mon_data.size() - base, 6);
        check_frame("limit+last", base, tx_q, 32'h005A_0026);
        chk("limit+last trunc", trunc, 0);

        // Reset mid-frame abandons the open frame
        sel = 1'b0;
        tick();
        tx_last_en = 1'b0;
        tx_q = '{16'h1111, 16'h2222, 16'h3333};
        send_frame(0);
        base = mon_data.size();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mid-rst s_ready", s_ready, 0);
        chk("mid-rst m_valid", m_valid, 0);
        chk("mid-rst m_data", m_data, 0);
        chk("mid-rst m_last", m_last, 0);
        chk("mid-rst trunc", trunc, 0);
        repeat (10) tick();
        chk("mid-rst no cksum", mon_data.size() - base, 0);
        tx_last_en = 1'b1;
        base = mon_data.size();
        tx_q = '{16'h0005, 16'h0006};
        send_frame(0);
        wait_out(base + 4);
        check_frame("post-rst", base, tx_q, 32'h0010_000B);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
